serial_frame_rx: RTL and testbench

//   Receiving end of the single-bit serial link that the D flip-flop stages

---
 rtl/serial_frame_rx.sv | 128 ++++++++++++
 tb/tb_serial_frame_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives start-bit-framed words from a single-bit serial
// line, one bit per rising clk edge, LSB first, with optional even parity.
//
// Frame on sin: start(1), d[0]..d[WIDTH-1], [parity if PARITY_EN], stop(0).
//
// Ports
//   clk        : rising-edge clock, sin sampled on every edge
//   reset      : asynchronous, active-high, clears all state and outputs
//   sin        : serial data, idle level 0
//   data_out   : last received word, held until the next frame completes
//   valid      : one-cycle pulse when a frame completes
//   parity_err : qualifies valid, parity mismatch (always 0 when PARITY_EN=0)
//   frame_err  : qualifies valid, stop bit was 1
//   busy       : high while a frame is being received
module serial_frame_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             r_par;
  logic             w_par_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic             w_perr_nxt;
  logic             w_ferr_nxt;
  logic             w_busy_nxt;

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      data_out   <= w_data_nxt;
      valid      <= w_valid_nxt;
      parity_err <= w_perr_nxt;
      frame_err  <= w_ferr_nxt;
      busy       <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_data_nxt  = data_out;
    w_valid_nxt = 1'b0;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (sin) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end

      S_DATA: begin
        w_shift_nxt[r_cnt] = sin;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_PARITY: begin
        w_par_nxt   = sin;
        w_state_nxt = S_STOP;
      end

      S_STOP: begin
        // A 1 here is a bad stop bit: it is consumed, never taken as a start.
        w_data_nxt  = r_shift;
        w_valid_nxt = 1'b1;
        w_ferr_nxt  = sin;
        w_perr_nxt  = PARITY_EN & (^{r_shift, r_par});
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: a WIDTH=8 parity build and a WIDTH=8 no-parity
// build, driven by directed frame tables, a mid-frame reset sequence and
// random frame streams, checked cycle by cycle against a frame-level model.
module tb_serial_frame_rx;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         sin1;
  logic         sin0;
  logic [W-1:0] d1, d0;
  logic         v1, pe1, fe1, b1;
  logic         v0, pe0, fe0, b0;

  always #5 clk = ~clk;

  serial_frame_rx #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .sin(sin1),
    .data_out(d1), .valid(v1), .parity_err(pe1), .frame_err(fe1), .busy(b1)
  );

  serial_frame_rx #(.WIDTH(W), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .reset(reset), .sin(sin0),
    .data_out(d0), .valid(v0), .parity_err(pe0), .frame_err(fe0), .busy(b0)
  );

  typedef struct packed {
    logic         v;
    logic         pe;
    logic         fe;
    logic         busy;
    logic [W-1:0] d;
  } obs_t;

  typedef struct {
    logic [W-1:0] data;
    bit           par_bad;
    bit           stop_bit;
    int           gap;
    logic [W-1:0] exp_d;
    bit           exp_pe;
    bit           exp_fe;
  } vec_t;

  bit           stream_q[$];
  obs_t         exp_q[$];
  logic [W-1:0] cur_d;
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic obs_t mk(input bit v, input bit pe, input bit fe,
                              input bit busy, input logic [W-1:0] d);
    obs_t o;
    o.v = v; o.pe = pe; o.fe = fe; o.busy = busy; o.d = d;
    return o;
  endfunction

  // Idle zeros: nothing changes, data_out holds.
  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      stream_q.push_back(1'b0);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, cur_d));
    end
  endfunction

  // One frame after 'gap' idle zeros; the result appears after the stop edge.
  function automatic void add_frame(input logic [W-1:0] data, input bit par_bad,
                                    input bit stop_bit, input int gap, input bit pe,
                                    input logic [W-1:0] exp_d, input bit exp_pe,
                                    input bit exp_fe);
    bit bits[$];
    bits.push_back(1'b1);
    for (int i = 0; i < int'(W); i++) bits.push_back(data[i]);
    if (pe) bits.push_back(bit'($countones(data) % 2) ^ par_bad);
    bits.push_back(stop_bit);
    add_idle(gap);
    for (int j = 0; j < bits.size(); j++) begin
      stream_q.push_back(bits[j]);
      if (j < bits.size() - 1) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, cur_d));
      else                     exp_q.push_back(mk(1'b1, exp_pe, exp_fe, 1'b0, exp_d));
    end
    cur_d = exp_d;
  endfunction

  task automatic check_obs(input string nm, input int idx, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got v=%b pe=%b fe=%b busy=%b d=%h, want v=%b pe=%b fe=%b busy=%b d=%h",
               nm, idx, act.v, act.pe, act.fe, act.busy, act.d,
               exp.v, exp.pe, exp.fe, exp.busy, exp.d);
    end
  endtask

  function automatic obs_t sample(input bit sel);
    return sel ? mk(v1, pe1, fe1, b1, d1) : mk(v0, pe0, fe0, b0, d0);
  endfunction

  // Drive the queued stream into one DUT and compare after every edge.
  task automatic run_stream(input bit sel, input string nm);
    for (int k = 0; k < stream_q.size(); k++) begin
      @(negedge clk);
      if (sel) sin1 = stream_q[k]; else sin0 = stream_q[k];
      @(posedge clk);
      #1;
      check_obs(nm, k, sample(sel), exp_q[k]);
    end
    @(negedge clk);
    sin1 = 1'b0;
    sin0 = 1'b0;
    stream_q.delete();
    exp_q.delete();
  endtask

  vec_t tbl[7];

  initial begin
    reset = 1'b1;
    sin1  = 1'b0;
    sin0  = 1'b0;
    cur_d = '0;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 3, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b0, 2, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{8'hA5, 1'b0, 1'b1, 0, 8'hA5, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 6, 8'h3C, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 1'b0, 0, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 1'b1, 1'b1, 1, 8'h80, 1'b1, 1'b1};

    // Reset state
    #12;
    check_obs("reset_par", 0, sample(1'b1), mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    check_obs("reset_nopar", 0, sample(1'b0), mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    @(negedge clk);
    reset = 1'b0;

    // Directed frames: good, parity error, stop error, back-to-back, both errors
    for (int i = 0; i < 7; i++)
      add_frame(tbl[i].data, tbl[i].par_bad, tbl[i].stop_bit, tbl[i].gap, 1'b1,
                tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe);
    add_idle(4);
    run_stream(1'b1, "table");

    // Reset after start + 4 data bits of 0x77, then a clean 0x5A frame
    begin
      bit part[5];
      part = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        sin1 = part[i];
        @(posedge clk);
      end
      #1;
      check_obs("midframe_busy", 0, sample(1'b1), mk(1'b0, 1'b0, 1'b0, 1'b1, cur_d));
      @(negedge clk);
      sin1  = 1'b0;
      reset = 1'b1;
      #1;
      check_obs("reset_async", 0, sample(1'b1), mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
      @(posedge clk);
      #1;
      check_obs("reset_held", 0, sample(1'b1), mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
      @(negedge clk);
      reset = 1'b0;
      cur_d = '0;
      add_idle(2);
      add_frame(8'h5A, 1'b0, 1'b0, 0, 1'b1, 8'h5A, 1'b0, 1'b0);
      add_idle(3);
      run_stream(1'b1, "after_reset");
    end

    // Random frames on the parity build
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] dat;
      bit pb, sb, pbit;
      dat  = W'($urandom);
      pb   = ($urandom % 4) == 0;
      sb   = ($urandom % 4) == 0;
      pbit = bit'($countones(dat) % 2) ^ pb;
      add_frame(dat, pb, sb, int'($urandom_range(0, 3)), 1'b1, dat,
                (($countones(dat) + int'(pbit)) % 2) == 1, sb);
    end
    add_idle(3);
    run_stream(1'b1, "rand_par");

    // No-parity build: long idle then 0xC3, then random frames
    cur_d = '0;
    add_frame(8'hC3, 1'b0, 1'b0, 50, 1'b0, 8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      logic [W-1:0] dat;
      bit sb;
      dat = W'($urandom);
      sb  = ($urandom % 4) == 0;
      add_frame(dat, 1'b0, sb, int'($urandom_range(0, 2)), 1'b0, dat, 1'b0, sb);
    end
    add_idle(3);
    run_stream(1'b0, "rand_nopar");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
